// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - streams a byte-wide program into word-addressed instruction memory
//
// Purpose:
//   Accepts program bytes over a valid/ready handshake and packs them
//   little-endian into 32-bit words. Each word is written to the instruction
//   memory with one write strobe, from word address 0 upward. done is raised
//   once DEPTH words are written so the core can leave reset and fetch.
//
// Optional feature (macro INSTR_LOADER_CHECKSUM_EN):
//   Defined   - an 8-bit running sum of all data bytes is kept. After the last
//               write, one trailer byte is accepted and error flags a mismatch.
//   Undefined - no trailer byte, error is tied to 0.
//
// Ports:
//   clock        in   1       rising-edge clock
//   reset        in   1       synchronous, active-high
//   start        in   1       begin a load (honoured in IDLE/DONE only)
//   byteIn       in   8       program byte
//   byteValid    in   1       byteIn is valid
//   byteReady    out  1       loader accepts a byte this cycle
//   writeEnable  out  1       one-cycle write strobe to instruction memory
//   writeAddress out  ADDR_W  word address of the write
//   writeData    out  32      instruction word of the write
//   busy         out  1       load in progress
//   done         out  1       program fully loaded, held until start/reset
//   wordCount    out  ADDR_W  words written so far
//   error        out  1       checksum mismatch

module instruction_loader #(
  parameter int DEPTH  = 6,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byteIn,
  input  logic              byteValid,
  output logic              byteReady,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] writeAddress,
  output logic [31:0]       writeData,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] wordCount,
  output logic              error
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHECK = 3'd4;
`endif

  // Address of the final word; the write to it ends the data phase.
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  logic [2:0]  state;
  logic [1:0]  byte_cnt;
  // Holds bytes 0..2 of the word being assembled; byte 0 ends up in [7:0].
  logic [23:0] word_sr;
  logic        byte_accept;

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]  sum;
  logic        error_q;
  assign byteReady = (state == ST_LOAD) || (state == ST_CHECK);
  assign busy      = (state == ST_LOAD) || (state == ST_WRITE) || (state == ST_CHECK);
  assign error     = error_q;
`else
  assign byteReady = (state == ST_LOAD);
  assign busy      = (state == ST_LOAD) || (state == ST_WRITE);
  assign error     = 1'b0;
`endif

  assign byte_accept = byteValid && byteReady;
  assign done        = (state == ST_DONE);
  // Reset in the WRITE cycle suppresses the strobe so the memory sees no write.
  assign writeEnable = (state == ST_WRITE) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      byte_cnt     <= 2'd0;
      word_sr      <= 24'd0;
      wordCount    <= '0;
      writeAddress <= '0;
      writeData    <= 32'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum          <= 8'd0;
      error_q      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_LOAD;
            byte_cnt  <= 2'd0;
            wordCount <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum       <= 8'd0;
            error_q   <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (byte_accept) begin
            word_sr  <= {byteIn, word_sr[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum      <= sum + byteIn;
`endif
            if (byte_cnt == 2'd3) begin
              // Capture address and data now so they stay stable through
              // the strobe and hold afterwards.
              writeAddress <= wordCount;
              writeData    <= {byteIn, word_sr};
              state        <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          wordCount <= wordCount + 1'b1;
          byte_cnt  <= 2'd0;
          if (wordCount == LAST_WORD) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            state <= ST_CHECK;
`else
            state <= ST_DONE;
`endif
          end else begin
            state <= ST_LOAD;
          end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (byte_accept) begin
            error_q <= (byteIn != sum);
            state   <= ST_DONE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - scoreboard bench for instruction_loader

module tb_instruction_loader;

  localparam int DEPTH  = 6;
  localparam int ADDR_W = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        byteIn = 8'd0;
  logic              byteValid = 1'b0;
  logic              byteReady;
  logic              writeEnable;
  logic [ADDR_W-1:0] writeAddress;
  logic [31:0]       writeData;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] wordCount;
  logic              error;

  instruction_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
    .busy(busy), .done(done), .wordCount(wordCount), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every observed write must match the head of the scoreboard.
  always @(negedge clock) begin
    if (writeEnable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr=0x%08h data=0x%08h, expected no write",
                 writeAddress, writeData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", writeAddress, e.addr);
        check("write_data", writeData, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte, optionally after an idle gap; wait (bounded) for acceptance.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 2);
      byteIn = 8'hA5;
      repeat (g) tick();
    end
    byteIn    = b;
    byteValid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (byteReady) ok = 1'b1;
      tick();
    end
    byteValid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL byte_accept_timeout: byteReady=0, expected 1 for byte 0x%02h", b);
    end
  endtask

  task automatic push_expected(input int nwords);
    for (int w = 0; w < nwords; w++) begin
      wr_t e;
      e.addr = w;
      e.data = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      if (done) ok = 1'b1;
    end
    check(name, {31'd0, done}, 32'd1);
    tick();
  endtask

  // Bytes 0x00..0x17, the trailer (if the checksum build) and wait for done.
  task automatic load_program(input bit gaps, input logic [7:0] trailer);
    push_expected(DEPTH);
    for (int i = 0; i < 4*DEPTH; i++) send_byte(8'(i), gaps);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(trailer, gaps);
`else
    byteIn = trailer;
`endif
    wait_done("done_after_load");
    check("wordcount_final", wordCount, 32'd6);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    check("addr_held", writeAddress, 32'd5);
    check("data_held", writeData, 32'h17161514);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    check("rst_byteready", {31'd0, byteReady}, 32'd0);
    check("rst_we", {31'd0, writeEnable}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wordcount", wordCount, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_addr", writeAddress, 32'd0);
    check("rst_data", writeData, 32'd0);

    // Valid in IDLE: nothing consumed, no write
    byteValid = 1'b1;
    byteIn    = 8'h77;
    repeat (3) tick();
    check("idle_byteready", {31'd0, byteReady}, 32'd0);
    byteValid = 1'b0;

    // Test 1: back-to-back stream
    pulse_start();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("ready_in_load", {31'd0, byteReady}, 32'd1);
    load_program(1'b0, 8'h14);
    check("error_good_sum", {31'd0, error}, 32'd0);

    // Valid in DONE: no consumption, no write, state held
    byteValid = 1'b1;
    repeat (4) tick();
    check("done_byteready", {31'd0, byteReady}, 32'd0);
    check("done_held", {31'd0, done}, 32'd1);
    check("done_wordcount", wordCount, 32'd6);
    byteValid = 1'b0;

    // Restart from DONE clears done and wordCount; random gaps in the stream
    pulse_start();
    check("restart_done_clr", {31'd0, done}, 32'd0);
    check("restart_wc_clr", wordCount, 32'd0);
    load_program(1'b1, 8'h14);

    // Start pulse mid-LOAD is ignored
    pulse_start();
    push_expected(DEPTH);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    pulse_start();
    check("midload_busy", {31'd0, busy}, 32'd1);
    for (int i = 2; i < 4*DEPTH; i++) send_byte(8'(i), 1'b0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(8'h14, 1'b0);
`endif
    wait_done("done_midload_start");
    check("midload_wordcount", wordCount, 32'd6);

    // Reset after the second write
    pulse_start();
    push_expected(2);
    for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b0);
    repeat (3) tick();
    check("pre_reset_wordcount", wordCount, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    check("post_reset_wordcount", wordCount, 32'd0);
    byteValid = 1'b1;
    repeat (5) tick();
    byteValid = 1'b0;

    // Reset during the WRITE cycle suppresses the strobe
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'(i), 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("reset_in_write_wc", wordCount, 32'd0);

    // Full reload after reset starts at address 0
    pulse_start();
    load_program(1'b1, 8'h14);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Bad trailer flags error; done still rises
    pulse_start();
    load_program(1'b0, 8'h15);
    check("error_bad_sum", {31'd0, error}, 32'd1);
    pulse_start();
    check("restart_error_clr", {31'd0, error}, 32'd0);
    load_program(1'b0, 8'h14);
    check("error_good_again", {31'd0, error}, 32'd0);
`endif

    repeat (3) tick();
    check("queue_empty_end", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
